freq_meter: RTL and testbench

Reciprocal companion to the frequency divider: instead of deriving a slow tick from the system clock, it measures the frequency of an external digital signal against the system clock. Rising edges of an asynchronous input are counted in decimal (BCD) over a fixed gate window, nominally 1 s at 100 MHz. At the end of each window the count is latched and a result-valid strobe is produced. The BCD output feeds the seven-segment scan/display path directly.

---
 rtl/freq_meter.sv | 98 +++++++++
 tb/tb_freq_meter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Counts synchronised rising edges of sig_in in BCD over a GATE_CYCLES window, then latches the count and strobes valid.
// Latency: edge counted 2 clk after sampling, result one cycle after gate end; no backpressure, valid is a one-cycle strobe.
module freq_meter #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int DIGITS      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sig_in,
    output logic [4*DIGITS-1:0]   freq_bcd,
    output logic                  overflow,
    output logic                  valid
);

    localparam int             G_W    = $clog2(GATE_CYCLES);
    localparam logic [G_W-1:0] G_LAST = G_W'(GATE_CYCLES - 1);

    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic [G_W-1:0]      r_g;
    logic [4*DIGITS-1:0] r_cnt;
    logic                r_ovf_run;

    logic                w_edge;
    logic                w_gate_end;
    logic                w_carry;
    logic                w_all9;
    logic                w_sat;
    logic [4*DIGITS-1:0] w_cnt_inc;
    logic [4*DIGITS-1:0] w_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge     = r_s2 & ~r_s3;
    assign w_gate_end = en & (r_g == G_LAST);

    // Ripple the BCD carry; a carry surviving past the top digit means every digit was 9.
    always_comb begin
        w_cnt_inc = r_cnt;
        w_carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_cnt[4*i +: 4] == 4'd9) begin
                    w_cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
        w_all9 = w_carry;
    end

    assign w_sat      = w_edge & w_all9;
    assign w_cnt_next = (w_edge && !w_all9) ? w_cnt_inc : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g       <= '0;
            r_cnt     <= '0;
            r_ovf_run <= 1'b0;
            freq_bcd  <= '0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
        end else if (!en) begin
            r_g       <= '0;
            r_cnt     <= '0;
            r_ovf_run <= 1'b0;
            valid     <= 1'b0;
        end else if (w_gate_end) begin
            // The gate-end edge belongs to the closing window.
            freq_bcd  <= w_cnt_next;
            overflow  <= r_ovf_run | w_sat;
            valid     <= 1'b1;
            r_g       <= '0;
            r_cnt     <= '0;
            r_ovf_run <= 1'b0;
        end else begin
            r_g       <= r_g + G_W'(1);
            r_cnt     <= w_cnt_next;
            r_ovf_run <= r_ovf_run | w_sat;
            valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: three instances cover short gate, BCD carry and 2-digit saturation.
module tb_freq_meter;

    logic        clk;
    logic        rst_a, rst_b, rst_c;
    logic        en_a, en_b, en_c;
    logic        sig_a, sig_b, sig_c;
    logic [15:0] freq_a, freq_b;
    logic [7:0]  freq_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        valid_a, valid_b, valid_c;

    int per_a, per_b, per_c;
    int ph_a, ph_b, ph_c;
    int checks;
    int errors;

    freq_meter #(.GATE_CYCLES(100), .DIGITS(4)) u_a (
        .clk(clk), .rst_n(rst_a), .en(en_a), .sig_in(sig_a),
        .freq_bcd(freq_a), .overflow(ovf_a), .valid(valid_a)
    );

    freq_meter #(.GATE_CYCLES(1000), .DIGITS(4)) u_b (
        .clk(clk), .rst_n(rst_b), .en(en_b), .sig_in(sig_b),
        .freq_bcd(freq_b), .overflow(ovf_b), .valid(valid_b)
    );

    freq_meter #(.GATE_CYCLES(1000), .DIGITS(2)) u_c (
        .clk(clk), .rst_n(rst_c), .en(en_c), .sig_in(sig_c),
        .freq_bcd(freq_c), .overflow(ovf_c), .valid(valid_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Square wave of period per (high first half); per == 0 leaves the signal to the main thread.
    task automatic gen(input int per, inout int ph, inout logic s);
        if (per == 0) begin
            ph = 0;
        end else begin
            s  = (ph < per / 2);
            ph = (ph + 1 >= per) ? 0 : ph + 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            gen(per_a, ph_a, sig_a);
            gen(per_b, ph_b, sig_b);
            gen(per_c, ph_c, sig_c);
        end
    end

    function automatic logic vld_of(input int w);
        case (w)
            0:       return valid_a;
            1:       return valid_b;
            default: return valid_c;
        endcase
    endfunction

    task automatic wait_valid(input int w, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld_of(w) && n < budget);
        chk($sformatf("vld_seen_%0d", w), 32'(vld_of(w)), 32'd1);
    endtask

    task automatic seq_a();
        int n;
        int bad;
        wait_valid(0, 200, n);
        chk("a_first_lat", n, 100);
        wait_valid(0, 200, n);
        chk("a_gap1", n, 100);
        chk("a_freq_w2", freq_a, 16'h0010);
        chk("a_ovf_w2", ovf_a, 0);
        @(negedge clk);
        chk("a_vld_width", valid_a, 0);
        wait_valid(0, 200, n);
        chk("a_gap2", n, 99);
        chk("a_freq_w3", freq_a, 16'h0010);

        // single pulse detected in the gate-end cycle
        per_a = 0;
        sig_a = 1'b0;
        wait_valid(0, 200, n);
        repeat (97) @(negedge clk);
        sig_a = 1'b1;
        @(negedge clk);
        sig_a = 1'b0;
        wait_valid(0, 200, n);
        chk("a_pulse_gap", n, 2);
        chk("a_gate_end_in", freq_a, 16'h0001);
        wait_valid(0, 200, n);
        chk("a_gate_end_next", freq_a, 16'h0000);

        // asynchronous reset mid-window
        per_a = 10;
        wait_valid(0, 200, n);
        wait_valid(0, 200, n);
        chk("a_freq_pre_rst", freq_a, 16'h0010);
        repeat (50) @(negedge clk);
        rst_a = 1'b0;
        per_a = 0;
        sig_a = 1'b0;
        #1;
        chk("a_rst_freq", freq_a, 0);
        chk("a_rst_ovf", ovf_a, 0);
        chk("a_rst_vld", valid_a, 0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        ph_a  = 0;
        per_a = 20;
        wait_valid(0, 200, n);
        chk("a_rst_lat", n, 100);
        chk("a_rst_freq1", freq_a, 16'h0005);

        // enable dropped mid-window
        per_a = 10;
        wait_valid(0, 200, n);
        wait_valid(0, 200, n);
        chk("a_freq_pre_en", freq_a, 16'h0010);
        repeat (40) @(negedge clk);
        en_a = 1'b0;
        bad  = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid_a) bad++;
        end
        chk("a_en_low_vld", bad, 0);
        chk("a_en_low_hold", freq_a, 16'h0010);
        en_a = 1'b1;
        wait_valid(0, 200, n);
        chk("a_en_lat", n, 100);
        chk("a_freq_post_en", freq_a, 16'h0010);
    endtask

    task automatic seq_b();
        int n;
        wait_valid(1, 1200, n);
        chk("b_first_lat", n, 1000);
        wait_valid(1, 1200, n);
        chk("b_gap", n, 1000);
        chk("b_freq_carry", freq_b, 16'h0100);
        chk("b_ovf", ovf_b, 0);
    endtask

    task automatic seq_c();
        int n;
        wait_valid(2, 1200, n);
        wait_valid(2, 1200, n);
        chk("c_freq_sat", freq_c, 8'h99);
        chk("c_ovf_set", ovf_c, 1);
        per_c = 0;
        sig_c = 1'b0;
        wait_valid(2, 1200, n);
        wait_valid(2, 1200, n);
        chk("c_freq_quiet", freq_c, 8'h00);
        chk("c_ovf_clear", ovf_c, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a  = 1'b0; en_b  = 1'b0; en_c  = 1'b0;
        sig_a = 1'b0; sig_b = 1'b0; sig_c = 1'b0;
        per_a = 0;    per_b = 0;    per_c = 0;
        ph_a  = 0;    ph_b  = 0;    ph_c  = 0;
        repeat (3) @(negedge clk);
        chk("rst_freq_a", freq_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_vld_a", valid_a, 0);
        chk("rst_freq_c", freq_c, 0);

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
        per_a = 10;   per_b = 10;   per_c = 4;
        fork
            seq_a();
            seq_b();
            seq_c();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
